load_store_unit: RTL and testbench
==================================

# load_store_unit

Processor-side initiator for the 32-byte data memory: accepts one load or store request at a time from the MIPS datapath and drives that memory's port (address, memWrite, memRead, writeData / readData). It always accesses the memory as aligned 32-bit little-endian words. Byte and halfword stores are performed as read-modify-write. Loaded bytes and halves are extracted and sign- or zero-extended. Misaligned or illegal requests are rejected without touching memory.

## Interface
Parameters
- ADDR_W, 5, byte-address width; memory holds 2^ADDR_W bytes

Ports
- clock  in  1  single clock; memory writes on posedge, updates readData on negedge
- resetn  in  1  synchronous, active-low reset
- req  in  1  request strobe; accepted only when ready=1
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- signedLoad  in  1  1 = sign-extend byte/half loads
- addr  in  ADDR_W  byte address
- wdata  in  32  store data; low byte/half used for sub-word stores
- ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = request rejected
- rdata  out  32  load result; valid with done, held until next done
- memAddress  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}
- memRead  out  1  memory read enable
- memWrite  out  1  memory write enable
- memWriteData  out  32  word written to memory
- memReadData  in  32  memory readData

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: ready=1. On req=1, register we, size, signedLoad, addr, wdata, then branch:
  - error (size=11; half with addr[0]=1; word with addr[1:0]≠0) → RESP with err=1
  - load → RD
  - word store → WR
  - byte/half store → RD
- RD: memRead=1, memAddress=base. At the closing posedge, capture memReadData into the hold register. Then load → RESP; sub-word store → WR.
- WR: memWrite=1.
  - Word store: memWriteData = wdata.
  - Byte store: hold word with lane addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
  - Half store: hold word with lane addr[1] (bits 16h+15:16h) replaced by wdata[15:0].
  - Next state: RESP.
- RESP: done=1 and err as decided; rdata updated only for a successful load; next state IDLE.
- Load extraction from the captured word, little-endian: byte k = bits[8k+7:8k]; half h = bits[16h+15:16h]. Sign-extend if signedLoad=1, otherwise zero-extend. Word loads are passed through unchanged.
- req while ready=0 is ignored; there is no queueing.
- Rejected requests never assert memRead or memWrite.
- Reset: state←IDLE. rdata, done, err, hold register and memWriteData ← 0. memRead and memWrite are decoded from state and gated by resetn, so they are 0 in any cycle with resetn=0. A write in progress therefore never commits at a reset edge. ready=0 during reset and 1 afterwards.

## Timing
- Request accepted at the posedge ending cycle T (IDLE).
- Load: RD in T+1, done in T+2.
- Word store: WR in T+1, done in T+2.
- Sub-word store: RD in T+1, WR in T+2, done in T+3.
- Rejected request: done with err=1 in T+1.
- Next request is accepted in the cycle after done, when the unit is back in IDLE.
- memReadData is sampled only at the posedge closing RD. It is valid after that cycle's negedge.
- memAddress, memWriteData, memRead and memWrite are stable for the whole RD/WR cycle.
- Word base ≤ 2^ADDR_W−4 always holds, so no access goes out of range.

## Test plan
- Freshly initialised memory (byte 16 = 0x02); load word at addr 16 → memRead high in T+1; done in T+2 with rdata=0x00000002, err=0.
- Store byte wdata=0x00000085 to addr 5, then:
  - load byte signed at 5 → rdata=0xFFFFFF85
  - load byte unsigned at 5 → rdata=0x00000085
  - load word at 4 → rdata=0x00008500
  - the store shows memRead in T+1, memWrite in T+2 with memWriteData=0x00008500, done in T+3.
- Store word 0xDEADBEEF to addr 8, then store half 0x1234 to addr 10 → load word at 8 = 0x1234BEEF; signed half load at 8 → 0xFFFFBEEF.
- Illegal requests: half at addr 3, word at addr 6, size=11 at addr 0 → each gives done with err=1 in T+1; memRead and memWrite stay 0; rdata unchanged.
- Reset and busy behaviour:
  - Drive resetn=0 during the WR cycle of a word store to addr 12 → memWrite=0 in that cycle; memory word 12 unchanged; after reset ready=1 and outputs are 0.
  - A second req pulsed while busy is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: single-request initiator for a word-wide data memory.
// Sub-word stores are read-modify-write; sub-word loads are extended.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              signedLoad,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] memAddress,
    output logic              memRead,
    output logic              memWrite,
    output logic [31:0]       memWriteData,
    input  logic [31:0]       memReadData
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              bad_req;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_word;
    logic [31:0]       wr_word;

    always_comb begin
        bad_req = 1'b0;
        unique case (size)
            SZ_BYTE: bad_req = 1'b0;
            SZ_HALF: bad_req = addr[0];
            SZ_WORD: bad_req = (addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    // Lane extraction from the word returned by memory during RD.
    always_comb begin
        ld_byte = memReadData[{addr_q[1:0], 3'b000} +: 8];
        ld_half = memReadData[{addr_q[1], 4'b0000} +: 16];
        ld_word = memReadData;
        unique case (size_q)
            SZ_BYTE: ld_word = sgn_q ? {{24{ld_byte[7]}}, ld_byte}
                                     : {24'h0, ld_byte};
            SZ_HALF: ld_word = sgn_q ? {{16{ld_half[15]}}, ld_half}
                                     : {16'h0, ld_half};
            default: ld_word = memReadData;
        endcase
    end

    // Merge the store lane into the word captured during RD.
    always_comb begin
        wr_word = hold_q;
        unique case (size_q)
            SZ_BYTE: wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wr_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sgn_d   = signedLoad;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = bad_req;
                    if (bad_req)
                        state_d = S_RESP;
                    else if (we && size == SZ_WORD)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                hold_d = memReadData;
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = ld_word;
                    state_d = S_RESP;
                end
            end
            S_WR:   state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            hold_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes are gated by resetn so a reset edge never commits a write.
    assign ready        = resetn && (state_q == S_IDLE);
    assign done         = resetn && (state_q == S_RESP);
    assign err          = done && err_q;
    assign memRead      = resetn && (state_q == S_RD);
    assign memWrite     = resetn && (state_q == S_WR);
    assign memAddress   = {addr_q[ADDR_W-1:2], 2'b00};
    assign memWriteData = wr_word;
    assign rdata        = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 32-byte
// behavioural memory (posedge write, negedge read).
module tb_load_store_unit;

    logic        clock;
    logic        resetn;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        signedLoad;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  memAddress;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    logic [7:0]  mem [32];
    logic        mem_clr;

    int n_checks;
    int n_fail;

    load_store_unit #(.ADDR_W(5)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req          (req),
        .we           (we),
        .size         (size),
        .signedLoad   (signedLoad),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .memAddress   (memAddress),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memWriteData (memWriteData),
        .memReadData  (memReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            mem[16] <= 8'h02;
        end else if (memWrite) begin
            mem[int'(memAddress)]     <= memWriteData[7:0];
            mem[int'(memAddress) + 1] <= memWriteData[15:8];
            mem[int'(memAddress) + 2] <= memWriteData[23:16];
            mem[int'(memAddress) + 3] <= memWriteData[31:24];
        end
    end

    always @(negedge clock)
        memReadData <= word_at(int'(memAddress));

    // Issues one request from IDLE and records per-cycle strobes until done.
    task automatic run_req(
        input  logic        w,
        input  logic [1:0]  s,
        input  logic        sg,
        input  logic [4:0]  a,
        input  logic [31:0] d,
        output int          lat,
        output logic [31:0] rd,
        output logic        e,
        output logic [7:0]  mr,
        output logic [7:0]  mw,
        output logic [31:0] mwd
    );
        @(negedge clock);
        we = w; size = s; signedLoad = sg; addr = a; wdata = d;
        req = 1'b1;
        lat = -1; rd = 32'h0; e = 1'b0;
        mr = 8'h0; mw = 8'h0; mwd = 32'h0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clock);
            req = 1'b0;
            mr[c] = memRead;
            mw[c] = memWrite;
            if (memWrite) mwd = memWriteData;
            if (done) begin
                lat = c; rd = rdata; e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00;
        signedLoad = 1'b0; addr = '0; wdata = 32'h0;
        mem_clr = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %b want 0", ready);
        end
        n_checks++;
        if ({memRead, memWrite, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 000",
                     {memRead, memWrite, done});
        end
        mem_clr = 1'b0;
        resetn = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_high: got %b want 1", ready);
        end
        n_checks++;
        if ({err, rdata, memWriteData, memAddress} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: err=%b rdata=%h mwd=%h ma=%h want 0",
                     err, rdata, memWriteData, memAddress);
        end
    endtask

    task automatic test_load_word();
        int lat; logic [31:0] rd; logic e;
        logic [7:0] mr, mw; logic [31:0] mwd;
        run_req(1'b0, 2'b10, 1'b0, 5'd16, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (lat !== 2 || mr !== 8'h02 || mw !== 8'h00) begin
            n_fail++;
            $display("FAIL load_word_timing: lat=%0d mr=%b mw=%b want 2 00000010 0",
                     lat, mr, mw);
        end
        n_checks++;
        if (rd !== 32'h00000002 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL load_word_data: got %h err=%b want 00000002 0", rd, e);
        end
    endtask

    task automatic test_byte_store();
        int lat; logic [31:0] rd; logic e;
        logic [7:0] mr, mw; logic [31:0] mwd;
        run_req(1'b1, 2'b00, 1'b0, 5'd5, 32'h00000085,
                lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (lat !== 3 || mr !== 8'h02 || mw !== 8'h04 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_timing: lat=%0d mr=%b mw=%b err=%b want 3 02 04 0",
                     lat, mr, mw, e);
        end
        n_checks++;
        if (mwd !== 32'h00008500) begin
            n_fail++; $display("FAIL sb_wdata: got %h want 00008500", mwd);
        end
        run_req(1'b0, 2'b00, 1'b1, 5'd5, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'hFFFFFF85 || lat !== 2) begin
            n_fail++; $display("FAIL lb_signed: got %h lat=%0d want FFFFFF85 2", rd, lat);
        end
        run_req(1'b0, 2'b00, 1'b0, 5'd5, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'h00000085) begin
            n_fail++; $display("FAIL lb_unsigned: got %h want 00000085", rd);
        end
        run_req(1'b0, 2'b10, 1'b0, 5'd4, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'h00008500) begin
            n_fail++; $display("FAIL lw_after_sb: got %h want 00008500", rd);
        end
    endtask

    task automatic test_half_store();
        int lat; logic [31:0] rd; logic e;
        logic [7:0] mr, mw; logic [31:0] mwd;
        run_req(1'b1, 2'b10, 1'b0, 5'd8, 32'hDEADBEEF,
                lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (lat !== 2 || mr !== 8'h00 || mw !== 8'h02 || mwd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw_timing: lat=%0d mr=%b mw=%b mwd=%h want 2 00 02 DEADBEEF",
                     lat, mr, mw, mwd);
        end
        run_req(1'b1, 2'b01, 1'b0, 5'd10, 32'hAAAA1234,
                lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (lat !== 3 || mwd !== 32'h1234BEEF) begin
            n_fail++;
            $display("FAIL sh_merge: lat=%0d mwd=%h want 3 1234BEEF", lat, mwd);
        end
        run_req(1'b0, 2'b10, 1'b0, 5'd8, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'h1234BEEF) begin
            n_fail++; $display("FAIL lw_after_sh: got %h want 1234BEEF", rd);
        end
        run_req(1'b0, 2'b01, 1'b1, 5'd8, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'hFFFFBEEF) begin
            n_fail++; $display("FAIL lh_signed: got %h want FFFFBEEF", rd);
        end
        run_req(1'b0, 2'b01, 1'b1, 5'd10, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'h00001234) begin
            n_fail++; $display("FAIL lh_upper: got %h want 00001234", rd);
        end
        run_req(1'b0, 2'b00, 1'b1, 5'd9, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'hFFFFFFBE) begin
            n_fail++; $display("FAIL lb_lane1: got %h want FFFFFFBE", rd);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic e;
        logic [7:0] mr, mw; logic [31:0] mwd;
        logic [1:0] sz [3];
        logic [4:0] ad [3];
        logic       ws [3];
        sz[0] = 2'b01; ad[0] = 5'd3; ws[0] = 1'b0;
        sz[1] = 2'b10; ad[1] = 5'd6; ws[1] = 1'b1;
        sz[2] = 2'b11; ad[2] = 5'd0; ws[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_req(ws[i], sz[i], 1'b0, ad[i], 32'h55555555,
                    lat, rd, e, mr, mw, mwd);
            n_checks++;
            if (lat !== 1 || e !== 1'b1 || mr !== 8'h00 || mw !== 8'h00) begin
                n_fail++;
                $display("FAIL illegal_%0d: lat=%0d err=%b mr=%b mw=%b want 1 1 0 0",
                         i, lat, e, mr, mw);
            end
            n_checks++;
            if (rd !== 32'hFFFFFFBE) begin
                n_fail++;
                $display("FAIL illegal_rdata_%0d: got %h want FFFFFFBE", i, rd);
            end
        end
        n_checks++;
        if (word_at(0) !== 32'h0 || word_at(4) !== 32'h00008500) begin
            n_fail++;
            $display("FAIL illegal_mem: w0=%h w4=%h want 0 00008500",
                     word_at(0), word_at(4));
        end
    endtask

    task automatic test_busy();
        logic seen;
        @(negedge clock);
        we = 1'b0; size = 2'b10; signedLoad = 1'b0; addr = 5'd16;
        req = 1'b1;
        @(negedge clock);
        we = 1'b1; addr = 5'd0; wdata = 32'hFFFFFFFF;
        n_checks++;
        if (ready !== 1'b0 || memRead !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rd: ready=%b memRead=%b want 0 1", ready, memRead);
        end
        @(negedge clock);
        req = 1'b0;
        n_checks++;
        if (done !== 1'b1 || rdata !== 32'h00000002 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_done: done=%b rdata=%h err=%b want 1 00000002 0",
                     done, rdata, err);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            seen = seen | memRead | memWrite | done;
        end
        n_checks++;
        if (seen !== 1'b0 || word_at(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL busy_ignored: activity=%b w0=%h want 0 0",
                     seen, word_at(0));
        end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [31:0] rd; logic e;
        logic [7:0] mr, mw; logic [31:0] mwd;
        @(negedge clock);
        we = 1'b1; size = 2'b10; addr = 5'd12; wdata = 32'hCAFEF00D;
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        n_checks++;
        if (memWrite !== 1'b1) begin
            n_fail++; $display("FAIL rst_wr_state: memWrite=%b want 1", memWrite);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (memWrite !== 1'b0) begin
            n_fail++; $display("FAIL rst_wr_gate: memWrite=%b want 0", memWrite);
        end
        @(negedge clock);
        n_checks++;
        if (ready !== 1'b0 || word_at(12) !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_hold: ready=%b w12=%h want 0 0", ready, word_at(12));
        end
        resetn = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 ||
            memWriteData !== 32'h0 || memRead !== 1'b0 || memWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs: rdy=%b done=%b err=%b rdata=%h mwd=%h mr=%b mw=%b",
                     ready, done, err, rdata, memWriteData, memRead, memWrite);
        end
        run_req(1'b0, 2'b10, 1'b0, 5'd12, 32'h0, lat, rd, e, mr, mw, mwd);
        n_checks++;
        if (rd !== 32'h0 || lat !== 2) begin
            n_fail++;
            $display("FAIL rst_w12_load: got %h lat=%0d want 00000000 2", rd, lat);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_word();
        test_byte_store();
        test_half_store();
        test_illegal();
        test_busy();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
